arqflowctrl_mlink: RTL
======================

# arqflowctrl_mlink

Per-link ARQ/SEQN/FLOW controller for the baseband bit-processing path, generalised from one active logical transport to NLINK simultaneous ACL links indexed by LT_ADDR. It sits beside the header and payload bit processors and the buffer controller. It consumes decoded header and payload-end strobes, keeps per-link acknowledge, sequence and flow state, and at each TX slot decides whether the link control sends a new packet, a retransmission or a NULL/POLL. An optional retransmission limit auto-flushes stalled links.

## Interface
Parameters:
- NLINK, 7, number of ACL links; LT_ADDR 1..NLINK valid (1..7).
- RETXW, 4, retransmission counter width.
- MAX_RETX, 15, retransmissions allowed before drop; 1..2^RETXW-1.

Ports:
- clk_6M  in  1  system clock, 6 MHz.
- rstz  in  1  asynchronous active-low reset.
- link_init_p  in  1  reinitialise one link's state (connection setup).
- link_init_addr  in  3  LT_ADDR for link_init_p.
- header_st_p  in  1  decoded RX header valid.
- dec_lt_addr  in  3  RX LT_ADDR.
- dec_hecgood, dec_arqn, dec_seqn, dec_flow  in  1 each  decoded header fields.
- dec_pktype  in  4  RX packet type; 0 = NULL, 1 = POLL.
- dec_py_endp  in  1  RX payload end.
- dec_crcgood  in  1  payload CRC result, valid with dec_py_endp.
- rxbuf_avail  in  1  RX ACL buffer can take a payload.
- tx_slot_p  in  1  TX decision request.
- tx_lt_addr  in  3  link to transmit on.
- txdata_avail  in  1  host has new data for tx_lt_addr.
- flush_p  in  1  flush the pending TX packet.
- flush_addr  in  3  link for flush_p.
- tx_valid_p  out  1  TX decision ready.
- tx_kind  out  2  00 NULL, 01 new, 10 retransmit, 11 POLL.
- tx_arqn, tx_seqn, tx_flow  out  1 each  header bits for the TX packet.
- rx_accept_p  out  1  new payload; buffer must store it.
- rx_dup_p  out  1  duplicate payload; discard it.
- retx_drop_p  out  1  retransmission limit hit, link flushed.
- link_pending  out  NLINK  bit i set = link i+1 has an unacknowledged packet.
- link_peerstop  out  NLINK  bit i set = link i+1 peer sent FLOW=0.

## Operation
- Per-link state: seqn_tx, seqn_rxlast, arqn, pending, peerstop, retx_cnt. Reset and link_init values: seqn_tx=1, seqn_rxlast=0, arqn=0, pending=0, peerstop=0, retx_cnt=0.
- The block ignores any address of 0 (broadcast) or greater than NLINK on every input.
- Header, with header_st_p, dec_hecgood=1 and a valid address:
  - peerstop <= ~dec_flow.
  - If pending and dec_arqn=1: pending <= 0, seqn_tx toggles, retx_cnt <= 0.
- Header with dec_hecgood=0: no state change.
- Latched RX address: the last good header's address is held for the following dec_py_endp.
- Payload end (dec_py_endp):
  - crcgood=1, rxbuf_avail=1, dec_seqn != seqn_rxlast: rx_accept_p, seqn_rxlast <= dec_seqn, arqn <= 1.
  - crcgood=1, dec_seqn == seqn_rxlast: rx_dup_p, arqn <= 1.
  - crcgood=0, or rxbuf_avail=0 on a new payload: arqn <= 0.
- Header-only packets: NULL and POLL leave arqn unchanged.
- TX decision (tx_slot_p), in priority order:
  - peerstop=1: tx_kind=11 if the local side is master (pending ignored), else 00.
  - pending=1: tx_kind=10, retx_cnt increments.
  - txdata_avail=1: tx_kind=01, pending <= 1.
  - Otherwise tx_kind=00.
- TX header bits: tx_seqn = seqn_tx after any ack from the same cycle; tx_arqn = link arqn; tx_flow = rxbuf_avail. After a TX decision, arqn <= 0 (ARQN is sent once). The master/slave selection uses rxbuf_avail-independent tie-off input-free rule: tx_kind 11 is produced only when txdata_avail=0, else 00.
- flush_p: pending <= 0, retx_cnt <= 0. seqn_tx toggles only if pending was 1.

## Timing
- All outputs are registered. Pulses last one cycle, 1 clk_6M after the input strobe. The bit-vector outputs update 1 cycle after the causing event.
- Reset values: all outputs 0.
- Simultaneous events, same link, same cycle:
  - link_init beats all other events.
  - flush beats a tx_slot decision.
  - A header ack is applied before a tx_slot decision.
- Simultaneous events on different links are all applied in the same cycle.
- Reset mid-operation clears all link state immediately.
- Sequence bits wrap modulo 2. retx_cnt saturates and never wraps.

## Configuration
- ARQ_RETX_LIMIT_EN defined:
  - A tx_slot with pending=1 and retx_cnt==MAX_RETX performs a flush instead of a retransmit.
  - That cycle produces retx_drop_p=1 and falls through to the new/NULL decision.
- ARQ_RETX_LIMIT_EN undefined: no limit, retx_cnt is not implemented, retx_drop_p ties to 0.

## Test plan
- Reset, then tx_slot_p on addr 1 with txdata_avail=1 -> tx_kind=01, tx_seqn=1, tx_arqn=0, link_pending=7'b0000001.
- Good header on addr 1 with dec_arqn=1, then tx_slot_p -> link_pending cleared, next new packet has tx_seqn=0.
- Two payloads on addr 2 with seqn 1, crcgood=1 -> first gives rx_accept_p, second gives rx_dup_p; both leave tx_arqn=1 on the next slot.
- Good header on addr 3 with dec_flow=0, pending=1, tx_slot_p -> link_peerstop[2]=1 and tx_kind is not 10.
- With ARQ_RETX_LIMIT_EN and MAX_RETX=2: three tx_slot_p with no ack -> kinds 01, 10, 10, then retx_drop_p=1 and pending=0.
- flush_p and tx_slot_p on the same link in the same cycle -> tx_kind≠10; link_init_p on the same cycle as a header -> state equals reset values.

Source files
------------

// File: rtl/arqflowctrl_mlink_if.sv
// arqflowctrl_mlink_if: strobe/field bundle between the baseband bit
// processors, the buffer controller and the per-link ARQ/SEQN/FLOW controller.
//
// Signalling: every *_p signal is a single-cycle strobe with no backpressure.
// The fields that go with a strobe (addresses, decoded header bits, CRC
// result, txdata_avail) are valid in the same cycle as that strobe. The
// controller answers each strobe exactly one clock later. rxbuf_avail is a
// level signal and is sampled whenever it is needed.
interface arqflowctrl_mlink_if #(
  parameter int NLINK = 7
);
  logic             link_init_p;
  logic [2:0]       link_init_addr;
  logic             header_st_p;
  logic [2:0]       dec_lt_addr;
  logic             dec_hecgood;
  logic             dec_arqn;
  logic             dec_seqn;
  logic             dec_flow;
  logic [3:0]       dec_pktype;
  logic             dec_py_endp;
  logic             dec_crcgood;
  logic             rxbuf_avail;
  logic             tx_slot_p;
  logic [2:0]       tx_lt_addr;
  logic             txdata_avail;
  logic             flush_p;
  logic [2:0]       flush_addr;
  logic             tx_valid_p;
  logic [1:0]       tx_kind;
  logic             tx_arqn;
  logic             tx_seqn;
  logic             tx_flow;
  logic             rx_accept_p;
  logic             rx_dup_p;
  logic             retx_drop_p;
  logic [NLINK-1:0] link_pending;
  logic [NLINK-1:0] link_peerstop;

  // Link control / bit-processor side: drives the strobes, reads decisions.
  modport master (
    output link_init_p, link_init_addr, header_st_p, dec_lt_addr, dec_hecgood,
           dec_arqn, dec_seqn, dec_flow, dec_pktype, dec_py_endp, dec_crcgood,
           rxbuf_avail, tx_slot_p, tx_lt_addr, txdata_avail, flush_p, flush_addr,
    input  tx_valid_p, tx_kind, tx_arqn, tx_seqn, tx_flow, rx_accept_p,
           rx_dup_p, retx_drop_p, link_pending, link_peerstop
  );

  // Controller side.
  modport slave (
    input  link_init_p, link_init_addr, header_st_p, dec_lt_addr, dec_hecgood,
           dec_arqn, dec_seqn, dec_flow, dec_pktype, dec_py_endp, dec_crcgood,
           rxbuf_avail, tx_slot_p, tx_lt_addr, txdata_avail, flush_p, flush_addr,
    output tx_valid_p, tx_kind, tx_arqn, tx_seqn, tx_flow, rx_accept_p,
           rx_dup_p, retx_drop_p, link_pending, link_peerstop
  );
endinterface

// File: rtl/arqflowctrl_mlink.sv
// arqflowctrl_mlink: per-link ARQ/SEQN/FLOW state for NLINK ACL links
// (LT_ADDR 1..NLINK). Applies decoded header/payload results and makes the
// per-slot TX decision: NULL, new packet, retransmission or POLL.
// Optional feature macro: ARQ_RETX_LIMIT_EN -- when defined, a link whose
// pending packet has been retransmitted MAX_RETX times is flushed at its next
// TX slot and retx_drop_p pulses.
// Within one cycle a link's events are applied in the order:
// link_init (overrides everything), header, flush, tx decision, payload end.
module arqflowctrl_mlink #(
  parameter int NLINK    = 7,
  parameter int RETXW    = 4,
  parameter int MAX_RETX = 15
) (
  input logic                clk_6M,
  input logic                rstz,
  arqflowctrl_mlink_if.slave lk
);
  // An out-of-range limit disables the drop path instead of comparing
  // against a truncated value.
  localparam logic CFG_OK = (MAX_RETX >= 1) && (MAX_RETX < (2 ** RETXW));

  logic [NLINK-1:0] seqn_tx_q, seqn_tx_n;
  logic [NLINK-1:0] seqn_rx_q, seqn_rx_n;
  logic [NLINK-1:0] arqn_q, arqn_n;
  logic [NLINK-1:0] pend_q, pend_n;
  logic [NLINK-1:0] pstop_q, pstop_n;
  logic [2:0]       rx_addr_q, rx_addr_n;
  logic             tx_valid_q, tx_valid_n;
  logic [1:0]       tx_kind_q, tx_kind_n;
  logic             tx_arqn_q, tx_arqn_n;
  logic             tx_seqn_q, tx_seqn_n;
  logic             tx_flow_q, tx_flow_n;
  logic             rx_accept_q, rx_accept_n;
  logic             rx_dup_q, rx_dup_n;
  logic             retx_drop_q, retx_drop_n;
  logic             retx_go;
`ifdef ARQ_RETX_LIMIT_EN
  logic [RETXW-1:0] retx_q [NLINK];
  logic [RETXW-1:0] retx_n [NLINK];
`endif

  // Next-state for every link plus the registered strobe outputs.
  always_comb begin
    seqn_tx_n   = seqn_tx_q;
    seqn_rx_n   = seqn_rx_q;
    arqn_n      = arqn_q;
    pend_n      = pend_q;
    pstop_n     = pstop_q;
    rx_addr_n   = rx_addr_q;
    tx_valid_n  = 1'b0;
    tx_kind_n   = tx_kind_q;
    tx_arqn_n   = tx_arqn_q;
    tx_seqn_n   = tx_seqn_q;
    tx_flow_n   = tx_flow_q;
    rx_accept_n = 1'b0;
    rx_dup_n    = 1'b0;
    retx_drop_n = 1'b0;
    retx_go     = 1'b0;
`ifdef ARQ_RETX_LIMIT_EN
    retx_n = retx_q;
`endif
    // A good header always re-targets the next payload end; address 0
    // latched here simply matches no link.
    if (lk.header_st_p && lk.dec_hecgood) rx_addr_n = lk.dec_lt_addr;

    for (int i = 0; i < NLINK; i++) begin
      if (lk.link_init_p && lk.link_init_addr == 3'(i + 1)) begin
        seqn_tx_n[i] = 1'b1;
        seqn_rx_n[i] = 1'b0;
        arqn_n[i]    = 1'b0;
        pend_n[i]    = 1'b0;
        pstop_n[i]   = 1'b0;
`ifdef ARQ_RETX_LIMIT_EN
        retx_n[i] = '0;
`endif
      end else begin
        // Header: flow state and acknowledgement of the pending packet.
        if (lk.header_st_p && lk.dec_hecgood && lk.dec_lt_addr == 3'(i + 1)) begin
          pstop_n[i] = ~lk.dec_flow;
          if (pend_n[i] && lk.dec_arqn) begin
            pend_n[i]    = 1'b0;
            seqn_tx_n[i] = ~seqn_tx_n[i];
`ifdef ARQ_RETX_LIMIT_EN
            retx_n[i] = '0;
`endif
          end
        end
        // Flush: the dropped packet's sequence number is consumed.
        if (lk.flush_p && lk.flush_addr == 3'(i + 1)) begin
          if (pend_n[i]) seqn_tx_n[i] = ~seqn_tx_n[i];
          pend_n[i] = 1'b0;
`ifdef ARQ_RETX_LIMIT_EN
          retx_n[i] = '0;
`endif
        end
        // TX decision on the state left by header and flush.
        if (lk.tx_slot_p && lk.tx_lt_addr == 3'(i + 1)) begin
          tx_valid_n = 1'b1;
          tx_arqn_n  = arqn_q[i];
          tx_flow_n  = lk.rxbuf_avail;
          arqn_n[i]  = 1'b0;
          if (pstop_n[i]) begin
            tx_kind_n = lk.txdata_avail ? 2'b00 : 2'b11;
          end else begin
            retx_go = pend_n[i];
`ifdef ARQ_RETX_LIMIT_EN
            if (pend_n[i] && CFG_OK && retx_n[i] == RETXW'(MAX_RETX)) begin
              pend_n[i]    = 1'b0;
              seqn_tx_n[i] = ~seqn_tx_n[i];
              retx_n[i]    = '0;
              retx_drop_n  = 1'b1;
              retx_go      = 1'b0;
            end
`endif
            if (retx_go) begin
              tx_kind_n = 2'b10;
`ifdef ARQ_RETX_LIMIT_EN
              if (retx_n[i] != '1) retx_n[i] = retx_n[i] + 1'b1;
`endif
            end else if (lk.txdata_avail) begin
              tx_kind_n = 2'b01;
              pend_n[i] = 1'b1;
            end else begin
              tx_kind_n = 2'b00;
            end
          end
          tx_seqn_n = seqn_tx_n[i];
        end
        // Payload end for the link of the last good header.
        if (lk.dec_py_endp && rx_addr_q == 3'(i + 1)) begin
          if (lk.dec_crcgood && lk.dec_seqn == seqn_rx_q[i]) begin
            rx_dup_n  = 1'b1;
            arqn_n[i] = 1'b1;
          end else if (lk.dec_crcgood && lk.rxbuf_avail) begin
            rx_accept_n  = 1'b1;
            seqn_rx_n[i] = lk.dec_seqn;
            arqn_n[i]    = 1'b1;
          end else begin
            arqn_n[i] = 1'b0;
          end
        end
      end
    end
  end

  // Link state and output registers.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      seqn_tx_q   <= '1;
      seqn_rx_q   <= '0;
      arqn_q      <= '0;
      pend_q      <= '0;
      pstop_q     <= '0;
      rx_addr_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_kind_q   <= 2'b00;
      tx_arqn_q   <= 1'b0;
      tx_seqn_q   <= 1'b0;
      tx_flow_q   <= 1'b0;
      rx_accept_q <= 1'b0;
      rx_dup_q    <= 1'b0;
      retx_drop_q <= 1'b0;
    end else begin
      seqn_tx_q   <= seqn_tx_n;
      seqn_rx_q   <= seqn_rx_n;
      arqn_q      <= arqn_n;
      pend_q      <= pend_n;
      pstop_q     <= pstop_n;
      rx_addr_q   <= rx_addr_n;
      tx_valid_q  <= tx_valid_n;
      tx_kind_q   <= tx_kind_n;
      tx_arqn_q   <= tx_arqn_n;
      tx_seqn_q   <= tx_seqn_n;
      tx_flow_q   <= tx_flow_n;
      rx_accept_q <= rx_accept_n;
      rx_dup_q    <= rx_dup_n;
      retx_drop_q <= retx_drop_n;
    end
  end

`ifdef ARQ_RETX_LIMIT_EN
  // Per-link retransmission counters.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      for (int i = 0; i < NLINK; i++) retx_q[i] <= '0;
    end else begin
      retx_q <= retx_n;
    end
  end
`endif

  assign lk.tx_valid_p    = tx_valid_q;
  assign lk.tx_kind       = tx_kind_q;
  assign lk.tx_arqn       = tx_arqn_q;
  assign lk.tx_seqn       = tx_seqn_q;
  assign lk.tx_flow       = tx_flow_q;
  assign lk.rx_accept_p   = rx_accept_q;
  assign lk.rx_dup_p      = rx_dup_q;
  assign lk.retx_drop_p   = retx_drop_q & CFG_OK;
  assign lk.link_pending  = pend_q;
  assign lk.link_peerstop = pstop_q;
endmodule
